// File: rtl/bf_uart_loader.sv
// bf_uart_loader: UART 8N1 receiver that filters Brainfuck opcodes into program memory.
// Optional bracket-balance checking is built when BF_LOADER_BRACKET_CHECK_EN is defined.
module bf_uart_loader #(
   parameter int CLK_HZ = 12000000,
   parameter int BAUD = 115200,
   parameter int ADDR_WIDTH = 12
) (
   input logic clk,
   input logic rst,
   input logic rx,
   input logic load_req,
   output logic prog_we,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   output logic [7:0] prog_data,
   output logic loading,
   output logic loaded,
   output logic [ADDR_WIDTH-1:0] prog_len,
   output logic overflow,
   output logic frame_err,
   output logic bracket_err
);
   localparam int CPB = CLK_HZ / BAUD;
   localparam int CW = $clog2(CPB + 1);
   localparam logic [CW-1:0] HALF_M = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M = CW'(CPB - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {IDLE, RECV, TERM, DONE} state_t;

   rx_state_t rs, rs_n;
   state_t state, state_n;
   logic [2:0] sync;
   logic rx_s, fall, tick, byte_done, bad_stop;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift, data_r;
   logic clr, wr, ovf_set, is_op, is_end, we_r;
   logic [ADDR_WIDTH-1:0] base_addr;

   // sync[1] is the synchronized line; sync[2] is its previous value for edge detection
   assign rx_s = sync[1];
   assign fall = sync[2] & ~sync[1];
   assign tick = (rs != R_IDLE) && (cnt == ((rs == R_START) ? HALF_M : FULL_M));
   assign byte_done = tick && rs == R_STOP && rx_s;
   assign bad_stop = tick && rs == R_STOP && !rx_s;
   assign is_op = shift inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
   assign is_end = shift == 8'h00 || shift == 8'h04;

   always_ff @(posedge clk or posedge rst)
      if (rst) rs <= R_IDLE;
      else rs <= rs_n;

   always_comb begin
      rs_n = rs;
      case (rs)
         R_IDLE: if (fall) rs_n = R_START;
         R_START: if (tick) rs_n = rx_s ? R_IDLE : R_DATA;
         R_DATA: if (tick && bit_idx == 3'd7) rs_n = R_STOP;
         default: if (tick) rs_n = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= '1;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
      end else begin
         sync <= {sync[1:0], rx};
         cnt <= (rs == R_IDLE || tick) ? '0 : cnt + 1'b1;
         if (rs == R_IDLE) bit_idx <= '0;
         if (tick && rs == R_DATA) begin
            shift <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   // A load_req restarts from address 0, and a byte completing in that cycle belongs to the new load
   always_comb begin
      state_n = state;
      clr = 1'b0;
      wr = 1'b0;
      ovf_set = 1'b0;
      base_addr = prog_addr;
      if (state == TERM) state_n = DONE;
      else begin
         clr = load_req;
         base_addr = load_req ? '0 : prog_addr;
         if (load_req) state_n = RECV;
         if ((state == RECV || load_req) && byte_done) begin
            wr = is_op && base_addr != LAST;
            ovf_set = is_op && base_addr == LAST;
            if (ovf_set || is_end) state_n = TERM;
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         prog_addr <= '0;
         we_r <= 1'b0;
         data_r <= '0;
         overflow <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (clr) prog_addr <= '0;
         else if (we_r) prog_addr <= prog_addr + 1'b1;
         we_r <= wr;
         if (wr) data_r <= shift;
         overflow <= (overflow && !clr) || ovf_set;
         frame_err <= (frame_err && !clr) || bad_stop;
      end

   assign prog_we = we_r || state == TERM;
   assign prog_data = (state == TERM) ? 8'h00 : data_r;
   assign prog_len = prog_addr;
   assign loading = state == RECV || state == TERM;
   assign loaded = state == DONE;

`ifdef BF_LOADER_BRACKET_CHECK_EN
   logic [ADDR_WIDTH-1:0] depth, depth_b;
   logic berr;
   assign depth_b = clr ? '0 : depth;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         depth <= '0;
         berr <= 1'b0;
      end else begin
         depth <= depth_b;
         if (clr) berr <= 1'b0;
         if (wr && shift == 8'h5B) depth <= depth_b + 1'b1;
         if (wr && shift == 8'h5D) begin
            if (depth_b == '0) berr <= 1'b1;
            else depth <= depth_b - 1'b1;
         end
         if (state_n == TERM && depth_b != '0) berr <= 1'b1;
      end
   assign bracket_err = berr;
`else
   assign bracket_err = 1'b0;
`endif
endmodule

// File: tb/tb_bf_uart_loader.sv
// tb_bf_uart_loader: directed and random UART program loads checked against a stream-level model.
module tb_bf_uart_loader;
   localparam int CPB = 10;
   localparam int AW = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx = 1'b1;
   logic load_req = 1'b0;
   logic prog_we, loading, loaded, overflow, frame_err, bracket_err;
   logic [AW-1:0] prog_addr, prog_len;
   logic [7:0] prog_data;
   int checks = 0;
   int errors = 0;
   logic [10:0] got[$];
   logic [10:0] exp_w[$];
   logic [8:0] stim[$];
   logic [AW-1:0] exp_len;
   logic exp_ovf, exp_fe, exp_be;
   logic term_prev = 1'b0;
   logic [7:0] ops[8] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
   logic [7:0] junk[4] = '{8'h61, 8'h0A, 8'h20, 8'h7F};

   bf_uart_loader #(.CLK_HZ(1000), .BAUD(100), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .rx(rx), .load_req(load_req),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .loading(loading), .loaded(loaded), .prog_len(prog_len),
      .overflow(overflow), .frame_err(frame_err), .bracket_err(bracket_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   always @(negedge clk) begin
      if (term_prev) chk("loaded_after_term", {31'b0, loaded}, 1);
      term_prev = !rst && prog_we && prog_data == 8'h00;
      if (term_prev) chk("loaded_at_term", {31'b0, loaded}, 0);
      if (!rst && prog_we) got.push_back({prog_addr, prog_data});
   end

   function automatic bit is_op(input logic [7:0] b);
      return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
   endfunction

   function automatic void add(input string t);
      for (int i = 0; i < t.len(); i++) stim.push_back({1'b0, t[i]});
   endfunction

   // Expected memory image and flags, computed from the byte stream as a whole
   function automatic void model(input logic [8:0] s[$]);
      int addr = 0;
      int depth = 0;
      bit done = 0;
      exp_w.delete();
      exp_ovf = 0;
      exp_fe = 0;
      exp_be = 0;
      foreach (s[i]) begin
         if (done) continue;
         if (s[i][8]) begin
            exp_fe = 1;
            continue;
         end
         if (is_op(s[i][7:0])) begin
            if (addr < 2**AW - 1) begin
               exp_w.push_back({AW'(addr), s[i][7:0]});
               addr++;
               if (s[i][7:0] == 8'h5B) depth++;
               else if (s[i][7:0] == 8'h5D) begin
                  if (depth == 0) exp_be = 1;
                  else depth--;
               end
            end else begin
               exp_ovf = 1;
               done = 1;
            end
         end else if (s[i][7:0] == 8'h00 || s[i][7:0] == 8'h04) done = 1;
         if (done) begin
            if (depth != 0) exp_be = 1;
            exp_w.push_back({AW'(addr), 8'h00});
         end
      end
      exp_len = AW'(addr);
`ifndef BF_LOADER_BRACKET_CHECK_EN
      exp_be = 0;
`endif
   endfunction

   task automatic send_byte(input logic [8:0] v);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         repeat (CPB) @(negedge clk);
      end
      rx = ~v[8];
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [8:0] s[$]);
      pulse_load();
      got.delete();
      chk({tag, "_loading"}, {31'b0, loading}, 1);
      chk({tag, "_loaded_clr"}, {31'b0, loaded}, 0);
      foreach (s[i]) send_byte(s[i]);
      repeat (4) @(negedge clk);
      model(s);
      chk({tag, "_nwrites"}, got.size(), exp_w.size());
      foreach (exp_w[i]) chk({tag, "_write"}, i < got.size() ? {21'b0, got[i]} : 'x, {21'b0, exp_w[i]});
      chk({tag, "_len"}, {29'b0, prog_len}, {29'b0, exp_len});
      chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
      chk({tag, "_frame_err"}, {31'b0, frame_err}, {31'b0, exp_fe});
      chk({tag, "_bracket_err"}, {31'b0, bracket_err}, {31'b0, exp_be});
      chk({tag, "_loaded"}, {31'b0, loaded}, 1);
      chk({tag, "_loading_end"}, {31'b0, loading}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outputs", {prog_we, prog_addr, prog_data, loading, loaded, prog_len, overflow, frame_err, bracket_err}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_outputs", {prog_we, prog_addr, prog_data, loading, loaded, prog_len, overflow, frame_err, bracket_err}, 0);

      got.delete();
      send_byte({1'b0, 8'h2B});
      repeat (4) @(negedge clk);
      chk("idle_no_write", got.size(), 0);
      chk("idle_loaded", {31'b0, loaded}, 0);

      stim.delete();
      add("+a>\n.");
      stim.push_back(9'h000);
      do_load("basic", stim);

      stim.delete();
      add("+++++++++");
      do_load("overflow", stim);

      stim.delete();
      stim.push_back(9'h12D);
      add("-");
      stim.push_back(9'h004);
      do_load("frame", stim);

      stim.delete();
      add("]+");
      stim.push_back(9'h000);
      do_load("br_close", stim);
      stim.delete();
      add("[[]");
      stim.push_back(9'h000);
      do_load("br_open", stim);
      stim.delete();
      add("[]");
      stim.push_back(9'h000);
      do_load("br_ok", stim);

      pulse_load();
      got.delete();
      send_byte({1'b0, 8'h2B});
      send_byte({1'b0, 8'h2D});
      repeat (4) @(negedge clk);
      chk("mid_writes", got.size(), 2);
      chk("mid_len", {29'b0, prog_len}, 2);
      stim.delete();
      add("<");
      stim.push_back(9'h000);
      do_load("restart", stim);

      for (int it = 0; it < 8; it++) begin
         int n;
         n = $urandom_range(3, 12);
         stim.delete();
         for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            logic bad;
            b = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 7)] : junk[$urandom_range(0, 3)];
            bad = (k < 3) && ($urandom_range(0, 4) == 0);
            stim.push_back({bad, b});
         end
         stim.push_back({1'b0, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h04});
         do_load("random", stim);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
